// File: rtl/cache_arb_pkg.sv
// Shared types for the cache bus arbiter: FSM state encoding and the
// owner encoding used by the grant logic and the top-level routing.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cache_arb_grant.sv
// Grant decision for cache_bus_arbiter: data beats inst, unless the optional
// starvation guard (CACHE_ARB_STARVE_GUARD_EN) decides inst has waited long enough.
module cache_arb_grant
  import cache_arb_pkg::*;
`ifdef CACHE_ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
`ifdef CACHE_ARB_STARVE_GUARD_EN
  input  logic aclk,
  input  logic aresetn,
  input  logic take_i,
`endif
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic valid_o,
  output logic owner_o
);

  assign valid_o = inst_req_i | data_req_i;

`ifdef CACHE_ARB_STARVE_GUARD_EN
  logic [3:0] streak_q, streak_d;
  logic       instDue;

  // The streak only counts data grants that actually made inst wait.
  assign instDue = inst_req_i && (streak_q == 4'(STARVE_LIMIT));
  assign owner_o = (data_req_i && !instDue) ? OWN_DATA : OWN_INST;

  always_comb begin
    streak_d = streak_q;
    if (take_i && valid_o) begin
      if ((owner_o == OWN_DATA) && inst_req_i) streak_d = streak_q + 4'd1;
      else                                     streak_d = 4'd0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) streak_q <= 4'd0;
    else          streak_q <= streak_d;
  end
`else
  assign owner_o = data_req_i ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/cache_bus_arbiter.sv
// Merges the i-cache and d-cache sram-like ports onto one sram-like master,
// one transaction at a time. Optional starvation guard: CACHE_ARB_STARVE_GUARD_EN.
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadStarveLimit
    $error("cache_bus_arbiter: STARVE_LIMIT must lie in 1..15");
  end

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  logic        kill_q, kill_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grantValid;
  logic        grantOwner;
  logic        instFlush;

  cache_arb_grant
`ifdef CACHE_ARB_STARVE_GUARD_EN
    #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
  uGrant (
`ifdef CACHE_ARB_STARVE_GUARD_EN
    .aclk       (aclk),
    .aresetn    (aresetn),
    .take_i     (state_q == IDLE),
`endif
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .valid_o    (grantValid),
    .owner_o    (grantOwner)
  );

  // A flush only poisons an inst transaction; the bus side still runs to completion.
  assign instFlush = flush && (owner_q == OWN_INST) && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    kill_d  = kill_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          state_d = ADDR;
          owner_d = arb_owner_t'(grantOwner);
          kill_d  = 1'b0;
          if (grantOwner == OWN_DATA) begin
            wr_d = data_wr; size_d = data_size; addr_d = data_addr; wdata_d = data_wdata;
          end else begin
            wr_d = inst_wr; size_d = inst_size; addr_d = inst_addr; wdata_d = inst_wdata;
          end
        end
      end
      ADDR: begin
        if (instFlush) kill_d = 1'b1;
        if (m_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (instFlush) kill_d = 1'b1;
        if (m_data_ok) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      kill_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign m_req   = (state_q == ADDR);
  assign m_wr    = wr_q;
  assign m_size  = size_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign inst_addr_ok = m_req && (owner_q == OWN_INST) && m_addr_ok;
  assign data_addr_ok = m_req && (owner_q == OWN_DATA) && m_addr_ok;
  // The current-cycle flush is folded in so a kill landing with m_data_ok still suppresses it.
  assign inst_data_ok = (state_q == DATA) && (owner_q == OWN_INST) && m_data_ok && !kill_q && !flush;
  assign data_data_ok = (state_q == DATA) && (owner_q == OWN_DATA) && m_data_ok;

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule
